// File: rtl/ppu_axis_packer_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the PPU AXI-Stream packer.
package ppu_axis_packer_pkg;

  localparam int ARRAY_COL = 16;
  localparam int VEC_W     = ARRAY_COL * 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int beats_per_vec(input int axis_w);
    return VEC_W / axis_w;
  endfunction

  // Index width that stays legal when only one value is needed.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_fifo.sv
// Vector FIFO with extended pointers; exposes the head and the entry behind it so the
// output stage can switch vectors without a bubble.
module vec_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_wdata,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_rdata,
  output logic [WIDTH-1:0]        o_rdata_nxt,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_push;
  logic              w_pop;
  logic [AW-1:0]     w_rd_nxt;

  assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_count     = r_wr_ptr - r_rd_ptr;
  assign w_pop       = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
  assign w_push      = i_push && (!o_full || w_pop);
  assign w_rd_nxt    = r_rd_ptr[AW-1:0] + AW'(1);
  assign o_rdata     = r_mem[r_rd_ptr[AW-1:0]];
  assign o_rdata_nxt = r_mem[w_rd_nxt];

  // Read/write pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/ppu_axis_packer.sv
// Packs 16-lane INT8 PPU vectors into AXI-Stream beats, framed by cfg_vec_count.
// Optional stall counter output enabled by defining PPU_PACKER_STALL_CNT_EN.
module ppu_axis_packer
  import ppu_axis_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AXIS_W     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [VEC_W-1:0]  i_data_vec,
  input  logic              cfg_start,
  input  logic [15:0]       cfg_vec_count,
  output logic [AXIS_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
`ifdef PPU_PACKER_STALL_CNT_EN
  ,
  output logic [31:0]       o_stall_cnt
`endif
);

  localparam int BEATS = beats_per_vec(AXIS_W);
  localparam int BW    = idx_w(BEATS);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               w_start_acc;
  logic               w_hs;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [AW:0]        w_count;
  logic [AW:0]        w_avail;
  logic [VEC_W-1:0]   w_head;
  logic [VEC_W-1:0]   w_head_nxt;
  logic [VEC_W-1:0]   w_src;
  logic               w_load;
  logic               w_nxt_valid;
  logic               w_nxt_last;
  logic [BW-1:0]      w_nxt_beat;
  logic [15:0]        w_nxt_idx;
  logic [AXIS_W-1:0]  w_nxt_data;

  logic [15:0]        r_vec_cnt;
  logic [15:0]        r_acc_cnt;
  logic [15:0]        r_pop_cnt;
  logic [BW-1:0]      r_beat;
  logic               r_tvalid;
  logic               r_tlast;
  logic [AXIS_W-1:0]  r_tdata;
  logic               r_done;
  logic               r_overflow;

  assign w_start_acc = cfg_start && (r_state == ST_IDLE);
  assign w_hs        = r_tvalid && m_axis_tready;
  assign w_pop       = w_hs && (r_beat == BEAT_LAST);
  assign w_push      = (r_state == ST_RUN) && i_valid && (!w_full || w_pop);

  vec_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_wdata     (i_data_vec),
    .i_pop       (w_pop),
    .o_rdata     (w_head),
    .o_rdata_nxt (w_head_nxt),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) w_state_nxt = ST_RUN;
        else           w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_push && (r_acc_cnt == r_vec_cnt - 16'd1)) w_state_nxt = ST_DRAIN;
        else                                            w_state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (w_hs && r_tlast) w_state_nxt = ST_IDLE;
        else                 w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame length latch and accepted/emitted vector counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec_cnt <= 16'd0;
      r_acc_cnt <= 16'd0;
      r_pop_cnt <= 16'd0;
    end else if (w_start_acc) begin
      r_vec_cnt <= (cfg_vec_count == 16'd0) ? 16'd1 : cfg_vec_count;
      r_acc_cnt <= 16'd0;
      r_pop_cnt <= 16'd0;
    end else begin
      if (w_push) r_acc_cnt <= r_acc_cnt + 16'd1;
      if (w_pop)  r_pop_cnt <= r_pop_cnt + 16'd1;
    end
  end

  // Sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                      r_overflow <= 1'b0;
    else if (w_start_acc)                                            r_overflow <= 1'b0;
    else if ((r_state == ST_RUN) && i_valid && w_full && !w_pop)     r_overflow <= 1'b1;
    else                                                             r_overflow <= r_overflow;
  end

  // Next output beat: same vector, next FIFO vector, or the vector being written right now
  // when nothing else is queued (gives one-cycle write-to-tvalid latency).
  always_comb begin
    w_load      = !r_tvalid || w_hs;
    w_nxt_valid = 1'b0;
    w_nxt_beat  = '0;
    w_src       = w_head;
    w_nxt_idx   = r_pop_cnt + {15'd0, w_pop};
    w_avail     = w_count - {{AW{1'b0}}, w_pop};
    if (r_tvalid && (r_beat != BEAT_LAST)) begin
      w_nxt_valid = 1'b1;
      w_nxt_beat  = r_beat + BW'(1);
    end else if (w_avail != '0) begin
      w_nxt_valid = 1'b1;
      w_src       = w_pop ? w_head_nxt : w_head;
    end else if (w_push) begin
      w_nxt_valid = 1'b1;
      w_src       = i_data_vec;
    end else begin
      w_nxt_valid = 1'b0;
    end
    w_nxt_data = w_src[int'(w_nxt_beat)*AXIS_W +: AXIS_W];
    w_nxt_last = w_nxt_valid && (w_nxt_beat == BEAT_LAST) && (w_nxt_idx == r_vec_cnt - 16'd1);
  end

  // Registered AXI-Stream output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_beat   <= '0;
    end else if (w_load) begin
      r_tvalid <= w_nxt_valid;
      r_tlast  <= w_nxt_last;
      r_tdata  <= w_nxt_valid ? w_nxt_data : '0;
      r_beat   <= w_nxt_beat;
    end else begin
      r_tvalid <= r_tvalid;
      r_tlast  <= r_tlast;
      r_tdata  <= r_tdata;
      r_beat   <= r_beat;
    end
  end

  // Frame completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= w_hs && r_tlast;
  end

`ifdef PPU_PACKER_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles where the sink holds off a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                    r_stall_cnt <= 32'd0;
    else if (w_start_acc)                                          r_stall_cnt <= 32'd0;
    else if (r_tvalid && !m_axis_tready && (r_stall_cnt != '1))    r_stall_cnt <= r_stall_cnt + 32'd1;
    else                                                           r_stall_cnt <= r_stall_cnt;
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign o_busy        = (r_state == ST_RUN);
  assign o_done        = r_done;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_ppu_axis_packer.sv
// Scoreboard bench for ppu_axis_packer: expected beats queued at stimulus, checked on handshake.
`timescale 1ns/1ps
module tb_ppu_axis_packer;

  localparam int VW    = 128;
  localparam int AW    = 64;
  localparam int BEATS = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           i_valid = 1'b0;
  logic [VW-1:0]  i_data_vec = '0;
  logic           cfg_start = 1'b0;
  logic [15:0]    cfg_vec_count = 16'd0;
  logic [AW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b0;
  logic           m_axis_tlast;
  logic           o_busy;
  logic           o_done;
  logic           o_overflow;
`ifdef PPU_PACKER_STALL_CNT_EN
  logic [31:0]    o_stall_cnt;
`endif

  ppu_axis_packer #(.FIFO_DEPTH(4), .AXIS_W(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .i_data_vec    (i_data_vec),
    .cfg_start     (cfg_start),
    .cfg_vec_count (cfg_vec_count),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_overflow    (o_overflow)
`ifdef PPU_PACKER_STALL_CNT_EN
    ,
    .o_stall_cnt   (o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  logic [AW:0]  sb[$];
  int           beat_cnt = 0;
  int           done_cnt = 0;
  int           exp_done = 0;
  int           frame_n = 1;
  int           acc_n = 0;
  logic         tog_en = 1'b0;
  logic         prev_stall = 1'b0;
  logic         prev_last_hs = 1'b0;
  logic         prev_last = 1'b0;
  logic [AW-1:0] prev_data = '0;

  // Output monitor: done timing, stall stability and scoreboard compare.
  always @(negedge clk) begin
    logic [AW:0] got;
    logic [AW:0] exp;
    if (!rst_n) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      checks++;
      if (o_done !== prev_last_hs) begin
        failures++;
        $display("FAIL done_pulse: got %b expected %b at %0t", o_done, prev_last_hs, $time);
      end
      if (o_done === 1'b1) done_cnt++;
      if (prev_stall) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          failures++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b", m_axis_tvalid,
                   m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        got = {m_axis_tlast, m_axis_tdata};
        checks++;
        beat_cnt++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL beat_unexpected: got %h expected no beat", got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            failures++;
            $display("FAIL beat_data: got last=%b data=%h expected last=%b data=%h",
                     got[AW], got[AW-1:0], exp[AW], exp[AW-1:0]);
          end
        end
      end
      prev_stall   = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
      prev_data    = m_axis_tdata;
      prev_last    = m_axis_tlast;
      prev_last_hs = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b1) && (m_axis_tlast === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [VW-1:0] mkvec(input logic [7:0] base);
    logic [VW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*8 +: 8] = base + 8'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (tog_en) m_axis_tready = ~m_axis_tready;
  endtask

  task automatic start_frame(input int n);
    cfg_start     = 1'b1;
    cfg_vec_count = 16'(n);
    frame_n       = (n == 0) ? 1 : n;
    acc_n         = 0;
    tick();
    cfg_start     = 1'b0;
  endtask

  task automatic push_vec(input logic [VW-1:0] data, input bit accept);
    logic [AW:0] e;
    i_valid    = 1'b1;
    i_data_vec = data;
    if (accept) begin
      acc_n++;
      for (int b = 0; b < BEATS; b++) begin
        e = {((acc_n == frame_n) && (b == BEATS-1)), data[b*AW +: AW]};
        sb.push_back(e);
      end
    end
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    exp_done++;
    for (int i = 0; i < 300; i++) begin
      if (done_cnt >= exp_done) break;
      tick();
    end
    checks++;
    if (done_cnt != exp_done) begin
      failures++;
      $display("FAIL %s_done_count: got %0d expected %0d", name, done_cnt, exp_done);
    end
    checks++;
    if (sb.size() != 0 || o_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_drained: got pending=%0d busy=%b expected pending=0 busy=0", name, sb.size(), o_busy);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, o_busy, o_done, o_overflow} !== 5'b0 || m_axis_tdata !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%b o=%b data=%h expected all 0",
               m_axis_tvalid, m_axis_tlast, o_busy, o_done, o_overflow, m_axis_tdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int b0;
    m_axis_tready = 1'b1;
    start_frame(3);
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy: got %b expected 1", o_busy);
    end
    b0 = beat_cnt;
    push_vec(mkvec(8'h00), 1'b1);
    @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h0706050403020100) begin
      failures++;
      $display("FAIL basic_first_beat: got v=%b d=%h expected v=1 d=0706050403020100", m_axis_tvalid, m_axis_tdata);
    end
    push_vec(mkvec(8'h10), 1'b1);
    push_vec(mkvec(8'h20), 1'b1);
    wait_done("basic");
    checks++;
    if (beat_cnt - b0 != 6) begin
      failures++;
      $display("FAIL basic_beats: got %0d expected 6", beat_cnt - b0);
    end
  endtask

  task automatic test_overflow();
    int b0;
    logic [VW-1:0] v0;
    v0 = mkvec(8'h40);
    m_axis_tready = 1'b0;
    start_frame(6);
    push_vec(v0, 1'b1);
    push_vec(mkvec(8'h50), 1'b1);
    push_vec(mkvec(8'h60), 1'b1);
    push_vec(mkvec(8'h70), 1'b1);
    push_vec(mkvec(8'h80), 1'b0);
    push_vec(mkvec(8'h90), 1'b0);
    @(negedge clk);
    checks++;
    if (o_overflow !== 1'b1 || dut.u_fifo.o_count !== 3'd4) begin
      failures++;
      $display("FAIL ovf_stored: got ovf=%b count=%0d expected ovf=1 count=4", o_overflow, dut.u_fifo.o_count);
    end
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== v0[AW-1:0]) begin
      failures++;
      $display("FAIL ovf_head_beat: got v=%b d=%h expected v=1 d=%h", m_axis_tvalid, m_axis_tdata, v0[AW-1:0]);
    end
    m_axis_tready = 1'b1;
    b0 = beat_cnt;
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (beat_cnt - b0 != 8 || m_axis_tvalid !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL ovf_hold: got beats=%0d v=%b busy=%b expected beats=8 v=0 busy=1",
               beat_cnt - b0, m_axis_tvalid, o_busy);
    end
    push_vec(mkvec(8'hA0), 1'b1);
    push_vec(mkvec(8'hB0), 1'b1);
    wait_done("ovf");
    checks++;
    if (o_overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: got %b expected 1", o_overflow);
    end
  endtask

  task automatic test_toggle();
    int b0;
    m_axis_tready = 1'b1;
    tog_en = 1'b1;
    start_frame(4);
    checks++;
    if (o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL toggle_ovf_clear: got %b expected 0", o_overflow);
    end
    b0 = beat_cnt;
    for (int i = 0; i < 4; i++) push_vec(mkvec(8'(8'hC0 + 8'(i*16))), 1'b1);
    wait_done("toggle");
    tog_en = 1'b0;
    m_axis_tready = 1'b1;
    checks++;
    if (beat_cnt - b0 != 8 || o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL toggle_beats: got beats=%0d ovf=%b expected beats=8 ovf=0", beat_cnt - b0, o_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    m_axis_tready = 1'b0;
    start_frame(5);
    for (int i = 0; i < 4; i++) push_vec(mkvec(8'(8'h11 + 8'(i*16))), 1'b1);
    @(negedge clk);
    m_axis_tready = 1'b1;
    tick();
    push_vec(mkvec(8'h55), 1'b1);
    @(negedge clk);
    checks++;
    if (o_overflow !== 1'b0 || dut.u_fifo.o_count !== 3'd4) begin
      failures++;
      $display("FAIL full_push_pop: got ovf=%b count=%0d expected ovf=0 count=4", o_overflow, dut.u_fifo.o_count);
    end
    wait_done("fullpp");
  endtask

  task automatic test_reset_midframe();
    int b0;
    m_axis_tready = 1'b1;
    start_frame(4);
    b0 = beat_cnt;
    push_vec(mkvec(8'h01), 1'b1);
    push_vec(mkvec(8'h21), 1'b1);
    for (int i = 0; i < 20 && (beat_cnt - b0) < 4; i++) tick();
    m_axis_tready = 1'b0;
    push_vec(mkvec(8'h41), 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, o_busy, o_done, o_overflow} !== 5'b0 || m_axis_tdata !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got v=%b l=%b b=%b d=%b o=%b data=%h expected all 0",
               m_axis_tvalid, m_axis_tlast, o_busy, o_done, o_overflow, m_axis_tdata);
    end
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    push_vec(mkvec(8'h61), 1'b0);
    @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b0 || o_busy !== 1'b0 || o_overflow !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle: got v=%b busy=%b ovf=%b expected 0 0 0", m_axis_tvalid, o_busy, o_overflow);
    end
    start_frame(4);
    for (int i = 0; i < 4; i++) push_vec(mkvec(8'(8'h03 + 8'(i*16))), 1'b1);
    wait_done("midreset");
  endtask

  task automatic test_zero_count();
    m_axis_tready = 1'b1;
    start_frame(0);
    push_vec(mkvec(8'hE0), 1'b1);
    wait_done("zero_cnt");
  endtask

`ifdef PPU_PACKER_STALL_CNT_EN
  task automatic test_stall_cnt();
    m_axis_tready = 1'b0;
    start_frame(1);
    push_vec(mkvec(8'hF0), 1'b1);
    repeat (10) tick();
    @(negedge clk);
    checks++;
    if (o_stall_cnt !== 32'd10) begin
      failures++;
      $display("FAIL stall_cnt: got %0d expected 10", o_stall_cnt);
    end
    m_axis_tready = 1'b1;
    wait_done("stall");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_toggle();
    test_full_push_pop();
    test_reset_midframe();
    test_zero_count();
`ifdef PPU_PACKER_STALL_CNT_EN
    test_stall_cnt();
`endif
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
